// File: rtl/branch_cmp_stage_pkg.sv
// Shared branch-type encodings and the per-entry status flags for the branch compare stage.
package branch_cmp_stage_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Width-independent part of a queue entry; the N-bit target is appended in the stage.
    typedef struct packed {
        logic taken;
        logic illegal;
        logic misaligned;
    } br_flags_t;

endpackage

// File: rtl/branch_cmp_stage_cond.sv
// Combinational branch condition evaluation for the six branch types.
module branch_cond_eval
    import branch_cmp_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] op_a_i,
    input  logic [N-1:0] op_b_i,
    input  logic [2:0]   funct3_i,
    output logic         taken_o,
    output logic         illegal_o
);

    logic lt_u;
    logic lt_s;

    always_comb begin
        lt_u = (op_a_i < op_b_i);
        // Differing signs: the negative operand is smaller.
        if (op_a_i[N-1] != op_b_i[N-1]) begin
            lt_s = op_a_i[N-1];
        end else begin
            lt_s = (op_a_i[N-2:0] < op_b_i[N-2:0]);
        end

        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            BR_EQ:   taken_o = (op_a_i == op_b_i);
            BR_NE:   taken_o = (op_a_i != op_b_i);
            BR_LT:   taken_o = lt_s;
            BR_GE:   taken_o = ~lt_s;
            BR_LTU:  taken_o = lt_u;
            BR_GEU:  taken_o = ~lt_u;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cmp_stage.sv
// Registered branch resolution stage: evaluates the condition and target at push time
// and buffers results in a 2-entry FIFO so the consumer can back-pressure.
module branch_cmp_stage
    import branch_cmp_stage_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] op_a_i,
    input  logic [N-1:0] op_b_i,
    input  logic [2:0]   funct3_i,
    input  logic [N-1:0] pc_i,
    input  logic [N-1:0] imm_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         taken_o,
    output logic [N-1:0] target_o,
    output logic         illegal_o,
    output logic         misaligned_o
);

    typedef struct packed {
        br_flags_t    flags;
        logic [N-1:0] target;
    } entry_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    entry_t     mem_q [2];
    entry_t     mem_d [2];

    logic       push;
    logic       pop;
    logic       cond_taken;
    logic       cond_illegal;
    entry_t     new_entry;
    entry_t     head;

    branch_cond_eval #(.N(N)) u_cond (
        .op_a_i    (op_a_i),
        .op_b_i    (op_b_i),
        .funct3_i  (funct3_i),
        .taken_o   (cond_taken),
        .illegal_o (cond_illegal)
    );

    assign in_ready_o  = (count_q != FULL);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        new_entry.target           = pc_i + imm_i;
        new_entry.flags.taken      = cond_taken;
        new_entry.flags.illegal    = cond_illegal;
        new_entry.flags.misaligned = cond_taken & (new_entry.target[1:0] != 2'b00);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Fields read as zero whenever the queue is empty, including straight out of reset.
    assign head         = mem_q[rd_ptr_q];
    assign taken_o      = out_valid_o & head.flags.taken;
    assign illegal_o    = out_valid_o & head.flags.illegal;
    assign misaligned_o = out_valid_o & head.flags.misaligned;
    assign target_o     = out_valid_o ? head.target : '0;

endmodule

// File: tb/tb_branch_cmp_stage.sv
// Self-checking bench for branch_cmp_stage: queue-based reference model plus directed literal checks.
module tb_branch_cmp_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        taken;
    logic [31:0] target;
    logic        illegal;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        taken;
        logic        illegal;
        logic        mis;
        logic [31:0] target;
    } exp_t;

    exp_t model_q[$];

    branch_cmp_stage #(.N(32), .DEPTH(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .funct3_i     (funct3),
        .pc_i         (pc),
        .imm_i        (imm),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .taken_o      (taken),
        .target_o     (target),
        .illegal_o    (illegal),
        .misaligned_o (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model_eval(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f, input logic [31:0] p,
                                        input logic [31:0] i);
        exp_t e;
        e.illegal = 1'b0;
        case (f)
            3'd0: e.taken = (a == b);
            3'd1: e.taken = (a != b);
            3'd4: e.taken = ($signed(a) < $signed(b));
            3'd5: e.taken = ($signed(a) >= $signed(b));
            3'd6: e.taken = (a < b);
            3'd7: e.taken = (a >= b);
            default: begin
                e.taken   = 1'b0;
                e.illegal = 1'b1;
            end
        endcase
        e.target = p + i;
        e.mis    = e.taken && (e.target % 4 != 0);
        return e;
    endfunction

    always @(posedge rst) model_q.delete();

    // Check current outputs, then predict the state after the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            bit do_pop;
            bit do_push;
            chk("in_ready", 32'(in_ready), 32'(model_q.size() != 2));
            chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                chk("taken", 32'(taken), 32'(model_q[0].taken));
                chk("illegal", 32'(illegal), 32'(model_q[0].illegal));
                chk("misaligned", 32'(misaligned), 32'(model_q[0].mis));
                chk("target", target, model_q[0].target);
            end
            if (flush) begin
                model_q.delete();
            end else begin
                do_pop  = (model_q.size() != 0) && out_ready;
                do_push = in_valid && (model_q.size() != 2);
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back(model_eval(op_a, op_b, funct3, pc, imm));
            end
        end
    end

    task automatic set_beat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                            input logic [31:0] p, input logic [31:0] i);
        op_a = a; op_b = b; funct3 = f; pc = p; imm = i;
    endtask

    // One-cycle push into an empty, draining queue; on return the beat is at the head.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input logic [31:0] p, input logic [31:0] i);
        set_beat(a, b, f, p, i);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] va [4];
        logic [31:0] vb [4];
        va[0] = 32'h7FFF_FFFF; vb[0] = 32'h8000_0000;
        va[1] = 32'h8000_0000; vb[1] = 32'h7FFF_FFFF;
        va[2] = 32'h0000_0005; vb[2] = 32'h0000_0005;
        va[3] = 32'h0000_0000; vb[3] = 32'hFFFF_FFFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_target", target, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Signed vs unsigned compares and equality
        send(32'hFFFF_FFFF, 32'h1, 3'b100, 32'h100, 32'h20);
        chk("blt_valid", 32'(out_valid), 32'd1);
        chk("blt_taken", 32'(taken), 32'd1);
        chk("blt_target", target, 32'h120);
        chk("blt_mis", 32'(misaligned), 32'd0);
        send(32'hFFFF_FFFF, 32'h1, 3'b110, 32'h100, 32'h20);
        chk("bltu_taken", 32'(taken), 32'd0);
        send(32'hFFFF_FFFF, 32'h1, 3'b111, 32'h100, 32'h20);
        chk("bgeu_taken", 32'(taken), 32'd1);
        send(32'h8000_0000, 32'h8000_0000, 3'b000, 32'h100, 32'h20);
        chk("beq_taken", 32'(taken), 32'd1);
        send(32'h8000_0000, 32'h8000_0000, 3'b001, 32'h100, 32'h20);
        chk("bne_taken", 32'(taken), 32'd0);

        // Target wrap and misalignment
        send(32'h5, 32'h5, 3'b000, 32'hFFFF_FFFC, 32'h8);
        chk("wrap_target", target, 32'h4);
        chk("wrap_mis", 32'(misaligned), 32'd0);
        send(32'h5, 32'h5, 3'b000, 32'hFFFF_FFFC, 32'h6);
        chk("mis_target", target, 32'h2);
        chk("mis_taken", 32'(misaligned), 32'd1);
        send(32'h5, 32'h6, 3'b000, 32'hFFFF_FFFC, 32'h6);
        chk("mis_nottaken", 32'(misaligned), 32'd0);

        // Illegal funct3 still queued
        send(32'h5, 32'h5, 3'b010, 32'h200, 32'h4);
        chk("illegal_flag", 32'(illegal), 32'd1);
        chk("illegal_taken", 32'(taken), 32'd0);
        @(posedge clk); #1;
        chk("illegal_popped", 32'(out_valid), 32'd0);

        // Back-pressure: third beat is refused while full
        out_ready = 1'b0;
        set_beat(32'h1, 32'h2, 3'b100, 32'h10, 32'h4);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_beat(32'h2, 32'h1, 3'b100, 32'h20, 32'h4);
        @(posedge clk); #1;
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        set_beat(32'h3, 32'h3, 3'b000, 32'h30, 32'h4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_head_target", target, 32'h14);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_same_cycle", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
        chk("bp_second_target", target, 32'h24);
        @(posedge clk); #1;
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush with two queued entries and a concurrent push/pop
        out_ready = 1'b0;
        send(32'h1, 32'h1, 3'b000, 32'h40, 32'h4);
        send(32'h1, 32'h1, 3'b000, 32'h50, 32'h4);
        flush = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);

        // Async reset pulse mid-cycle
        out_ready = 1'b0;
        send(32'h1, 32'h1, 3'b000, 32'h60, 32'h4);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_taken", 32'(taken), 32'd0);
        chk("arst_target", target, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Sweep of operand pairs across all funct3 values with intermittent back-pressure
        for (int i = 0; i < 32; i++) begin
            int  tries;
            bit  acc;
            set_beat(va[i / 8], vb[i / 8], 3'(i % 8), 32'(i * 4), 32'(i * 2));
            in_valid  = 1'b1;
            out_ready = i[0];
            tries = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                out_ready = ~out_ready;
                tries++;
            end while (!acc && tries < 10);
            in_valid = 1'b0;
            if (!acc) chk("sweep_accept_timeout", 32'd0, 32'd1);
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("sweep_drained", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
